imm_extend_pipe: RTL

//  Parametrised, registered immediate extender for the decode/execute boundary.

---
 rtl/imm_extend_pipe.sv | 112 +++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender (zero / sign / upper / sign<<2) feeding a
// 2-entry skid buffer with valid/ready handshakes on both sides.
module imm_extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  localparam int E = OUT_W - IN_W;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [OUT_W-1:0] main_data_q, main_data_d;
  logic [TAG_W-1:0] main_tag_q, main_tag_d;
  logic [OUT_W-1:0] skid_data_q, skid_data_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

  logic [OUT_W-1:0] zext, sext, ext;
  logic             accept, fire;

  assign zext = {{E{1'b0}}, in_data};
  assign sext = {{E{in_data[IN_W-1]}}, in_data};

  // Shifting the full-width sign extension drops its top two copies of the
  // sign bit, which yields the (E-2)-copy branch form even when E == 2.
  always_comb begin
    ext = zext;
    case (in_mode)
      2'b00:   ext = zext;
      2'b01:   ext = sext;
      2'b10:   ext = zext << E;
      default: ext = sext << 2;
    endcase
  end

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_data_q;
  assign out_tag   = main_tag_q;

  assign accept = in_valid & in_ready;
  assign fire   = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_tag_d  = main_tag_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_data_d = ext;
          main_tag_d  = in_tag;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && fire) begin
          main_data_d = ext;
          main_tag_d  = in_tag;
        end else if (accept) begin
          skid_data_d = ext;
          skid_tag_d  = in_tag;
          state_d     = ST_FULL;
        end else if (fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (fire) begin
          main_data_d = skid_data_q;
          main_tag_d  = skid_tag_q;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_tag_q  <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_tag_q  <= main_tag_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
    end
  end

endmodule
